// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
// Overflow policy selectors are compared against the OVF_MODE parameter.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OVF_STOP = 0;
  localparam int OVF_WRAP = 1;

endpackage

// File: rtl/fib_core.sv
// Term datapath: holds the current/next term pair and tracks whether the
// next term has left the representable range.
module fib_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] a,
  output logic             b_ovf
);

  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // b_ovf is sticky: once a term is unrepresentable, all later ones are too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      b_ovf <= 1'b0;
    end else if (load) begin
      a     <= seed0;
      b     <= seed1;
      b_ovf <= 1'b0;
    end else if (advance) begin
      a     <= b;
      b     <= sum[WIDTH-1:0];
      b_ovf <= b_ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Start-triggered, bounded Fibonacci-type term source with a valid/ready
// output stream, index tagging and a selectable overflow policy.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IDX_W    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam bit STOP_MODE = (OVF_MODE == OVF_STOP);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic             load;
  logic             advance;
  logic             fire;
  logic             last;
  logic             b_ovf;
  logic [WIDTH-1:0] a;

  fib_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .seed0   (seed0),
    .seed1   (seed1),
    .a       (a),
    .b_ovf   (b_ovf)
  );

  assign fire = (state_reg == RUN) && out_ready;
  assign last = (idx_reg == count_reg - IDX_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    load          = 1'b0;
    advance       = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          overflow_next = 1'b0;
          count_next    = count;
          idx_next      = '0;
          if (count == '0) begin
            state_next = DONE;
          end else begin
            load       = 1'b1;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (fire) begin
          if (last) begin
            state_next = DONE;
          end else if (STOP_MODE && b_ovf) begin
            // Next term is unrepresentable: end on the largest valid one.
            state_next    = DONE;
            overflow_next = 1'b1;
          end else begin
            advance  = 1'b1;
            idx_next = idx_reg + IDX_W'(1);
            if (b_ovf) begin
              overflow_next = 1'b1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == RUN);
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign out_data  = a;
  assign out_idx   = idx_reg;
  assign overflow  = overflow_reg;

endmodule
